axil_master: RTL

Single-outstanding AXI4-Lite initiator converting the core's simple load/store request port into AXI4-Lite read and write transactions. It sits between the core's data port and the AXI4-Lite interconnect that fronts `clint` and the other memory-mapped peripherals. One transaction is in flight at a time. The AXI response code is returned to the core as an error flag.

---
 rtl/axil_master.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/axil_master.sv
// Single-outstanding AXI4-Lite initiator bridging a simple load/store request port to AXI4-Lite.
// Optional AXIL_MASTER_ALIGN_CHECK_EN: misaligned requests complete locally with rsp_err=1.
module axil_master #(
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned AXI_DATA_WIDTH = 32
) (
  input  logic                          m_axi_aclk,
  input  logic                          m_axi_areset,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic                          req_write,
  input  logic [AXI_ADDR_WIDTH-1:0]     req_addr,
  input  logic [AXI_DATA_WIDTH-1:0]     req_wdata,
  input  logic [AXI_DATA_WIDTH/8-1:0]   req_wstrb,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [AXI_DATA_WIDTH-1:0]     rsp_rdata,
  output logic                          rsp_err,
  output logic [AXI_ADDR_WIDTH-1:0]     m_axi_awaddr,
  output logic [2:0]                    m_axi_awprot,
  output logic                          m_axi_awvalid,
  input  logic                          m_axi_awready,
  output logic [AXI_DATA_WIDTH-1:0]     m_axi_wdata,
  output logic [AXI_DATA_WIDTH/8-1:0]   m_axi_wstrb,
  output logic                          m_axi_wvalid,
  input  logic                          m_axi_wready,
  input  logic [1:0]                    m_axi_bresp,
  input  logic                          m_axi_bvalid,
  output logic                          m_axi_bready,
  output logic [AXI_ADDR_WIDTH-1:0]     m_axi_araddr,
  output logic [2:0]                    m_axi_arprot,
  output logic                          m_axi_arvalid,
  input  logic                          m_axi_arready,
  input  logic [AXI_DATA_WIDTH-1:0]     m_axi_rdata,
  input  logic [1:0]                    m_axi_rresp,
  input  logic                          m_axi_rvalid,
  output logic                          m_axi_rready
);

  localparam int unsigned STRB_W = AXI_DATA_WIDTH / 8;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WADDR_DATA = 3'd1,
    WRESP      = 3'd2,
    RADDR      = 3'd3,
    RRESP      = 3'd4,
    RESP       = 3'd5
  } state_t;

  state_t                     state_q, state_d;
  logic                       aw_done_q, aw_done_d;
  logic                       w_done_q, w_done_d;
  logic [AXI_ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [AXI_DATA_WIDTH-1:0]  wdata_d;
  logic [STRB_W-1:0]          wstrb_d;
  logic [AXI_DATA_WIDTH-1:0]  rdata_d;
  logic                       err_d;

  assign m_axi_awprot = 3'b000;
  assign m_axi_arprot = 3'b000;
  // Both address channels share the one registered, word-aligned request address.
  assign m_axi_awaddr = addr_q;
  assign m_axi_araddr = addr_q;

  // Next-state, captured request and response values.
  always_comb begin
    state_d   = state_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    addr_d    = addr_q;
    wdata_d   = m_axi_wdata;
    wstrb_d   = m_axi_wstrb;
    rdata_d   = rsp_rdata;
    err_d     = rsp_err;
    case (state_q)
      IDLE: begin
        aw_done_d = 1'b0;
        w_done_d  = 1'b0;
        if (req_valid && req_ready) begin
          addr_d  = req_addr & ~(AXI_ADDR_WIDTH'(3));
          wdata_d = req_wdata;
          wstrb_d = req_wstrb;
          state_d = req_write ? WADDR_DATA : RADDR;
`ifdef AXIL_MASTER_ALIGN_CHECK_EN
          if (req_addr[1:0] != 2'b00) begin
            state_d = RESP;
            rdata_d = '0;
            err_d   = 1'b1;
          end
`endif
        end
      end
      WADDR_DATA: begin
        if (m_axi_awvalid && m_axi_awready) aw_done_d = 1'b1;
        if (m_axi_wvalid && m_axi_wready)   w_done_d  = 1'b1;
        if (aw_done_d && w_done_d)          state_d   = WRESP;
      end
      WRESP: begin
        if (m_axi_bready && m_axi_bvalid) begin
          err_d   = (m_axi_bresp != 2'b00);
          rdata_d = '0;
          state_d = RESP;
        end
      end
      RADDR: begin
        if (m_axi_arvalid && m_axi_arready) state_d = RRESP;
      end
      RRESP: begin
        if (m_axi_rready && m_axi_rvalid) begin
          err_d   = (m_axi_rresp != 2'b00);
          rdata_d = m_axi_rdata;
          state_d = RESP;
        end
      end
      RESP: begin
        if (rsp_valid && rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge m_axi_aclk or posedge m_axi_areset) begin
    if (m_axi_areset) begin
      state_q   <= IDLE;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

  // Registered outputs, decoded from the next state so they line up with it.
  always_ff @(posedge m_axi_aclk or posedge m_axi_areset) begin
    if (m_axi_areset) begin
      req_ready     <= 1'b0;
      rsp_valid     <= 1'b0;
      rsp_rdata     <= '0;
      rsp_err       <= 1'b0;
      addr_q        <= '0;
      m_axi_wdata   <= '0;
      m_axi_wstrb   <= '0;
      m_axi_awvalid <= 1'b0;
      m_axi_wvalid  <= 1'b0;
      m_axi_bready  <= 1'b0;
      m_axi_arvalid <= 1'b0;
      m_axi_rready  <= 1'b0;
    end else begin
      req_ready     <= (state_d == IDLE);
      rsp_valid     <= (state_d == RESP);
      rsp_rdata     <= rdata_d;
      rsp_err       <= err_d;
      addr_q        <= addr_d;
      m_axi_wdata   <= wdata_d;
      m_axi_wstrb   <= wstrb_d;
      m_axi_awvalid <= (state_d == WADDR_DATA) && !aw_done_d;
      m_axi_wvalid  <= (state_d == WADDR_DATA) && !w_done_d;
      m_axi_bready  <= (state_d == WRESP);
      m_axi_arvalid <= (state_d == RADDR);
      m_axi_rready  <= (state_d == RRESP);
    end
  end

endmodule
